ex_mem_pipe_stage: RTL and testbench
====================================

// Module: ex_mem_pipe_stage
// PURPOSE
//  Elastic EX->MEM pipeline stage; parametrised successor of the fixed EX/MEM register.
//  Adds valid/ready handshake, flush, synchronous reset, bubble-safe write enables and a stall counter.
//  Sits between the ALU/branch stage and the data-memory/writeback stage of the pipelined core.
// PARAMETERS
//  DBITS                32  datapath width: ALU result, PC+4, store data
//  REG_INDEX_BIT_WIDTH  4   register-file index width
//  STALL_CNT_BITS       16  width of the saturating stall counter
// PORTS
//  clk               in   1      clock, rising edge
//  reset_n           in   1      synchronous, active-low reset
//  flush             in   1      kill all held entries (branch/jal redirect)
//  in_valid          in   1      upstream payload valid
//  in_ready          out  1      stage can accept this cycle
//  alu_out           in   DBITS  ALU result (memory address / writeback data)
//  pc_inc            in   DBITS  PC+4 for jal link
//  dmem_data_in      in   DBITS  store data
//  dmem_wrt_en       in   1      store enable
//  mem_to_reg        in   1      writeback-select: memory
//  jal               in   1      writeback-select: link
//  reg_file_wrt_en   in   1      register write enable
//  reg_wrt_index     in   RIW    destination register
//  out_valid         out  1      downstream payload valid
//  out_ready         in   1      downstream accepts
//  dmem_addr_out / reg_file_alu_out_out  out DBITS  registered alu_out (same value on both)
//  dmem_data_in_out, pc_inc_out          out DBITS  registered payload
//  dmem_wrt_en_out, reg_file_wrt_en_out  out 1      registered enable AND out_valid
//  mem_to_reg_out, jal_out               out 1      registered selectors
//  reg_wrt_index_out                     out RIW    registered index
//  stall_cnt         out  STALL_CNT_BITS  cycles with out_valid && !out_ready, saturating
// BEHAVIOUR
//  - Reset (reset_n==0 at posedge): all valid bits 0, every payload register 0, stall_cnt 0.
//    Outputs after reset: out_valid=0, all *_out=0; in_ready=1 with no skid, 0 for one cycle with skid.
//  - Transfer in: in_valid && in_ready at posedge. Transfer out: out_valid && out_ready at posedge.
//  - Latency: 1 cycle input->output when the stage is empty; throughput 1 transfer/cycle.
//  - Payload registers load only on an input transfer; held stable while out_valid && !out_ready.
//  - Bubble safety: dmem_wrt_en_out and reg_file_wrt_en_out are 0 whenever out_valid==0.
//  - Flush: at posedge, clears all valid bits; the same-cycle input is dropped (in_ready still
//    reported, but nothing stored). Payload registers may keep stale data; enables still gated.
//  - Flush has priority over simultaneous in/out transfers; reset has priority over flush.
//  - Reset mid-stall: stored entry discarded, stall_cnt cleared.
//  - stall_cnt: +1 each cycle out_valid && !out_ready; holds at 2^STALL_CNT_BITS-1; never wraps.
//  - Simultaneous in and out transfer on a full main register: new payload replaces old, valid stays 1.
// CONFIGURATION
//  PIPE_SKID_EN undefined: single register; in_ready = !out_valid || out_ready (combinational path).
//  PIPE_SKID_EN defined: 2-entry skid buffer; in_ready is a flop (no combinational ready path).
//    States EMPTY(main empty) -> BUSY(main full) -> FULL(main+skid full).
//    EMPTY: in xfer -> BUSY. BUSY: in&&!out -> FULL (into skid); out&&!in -> EMPTY; both -> BUSY.
//    FULL: in_ready=0; out xfer -> skid moves to main, BUSY. Flush -> EMPTY from any state.
//    Order preserved; latency unchanged; in_ready = (next state != FULL).
// STRUCTURE
//  Package ex_mem_pkg: ex_mem_payload_t packed struct (all payload fields), DBITS/RIW defaults,
//    skid state enum {EMPTY, BUSY, FULL}.
//  Sub-module ex_mem_skid_buf: holds the skid entry and state FSM; instantiated only under PIPE_SKID_EN.
//  Top: main payload register, valid bit, enable gating, stall counter.
// TESTING
//  1. Reset: hold reset_n=0 3 cycles with in_valid=1 -> out_valid=0, all outputs 0, stall_cnt=0.
//  2. Stream: 8 back-to-back in (alu_out=0x10..0x17), out_ready=1 -> same values out, 1-cycle lag, no gaps.
//  3. Stall: load alu_out=0xDEAD, out_ready=0 for 5 cycles -> output held 0xDEAD, stall_cnt=5; release -> 1 transfer.
//  4. Flush: stage holding dmem_wrt_en=1, assert flush with in_valid=1 -> next cycle out_valid=0, dmem_wrt_en_out=0.
//  5. Saturation: STALL_CNT_BITS=4, stall 20 cycles -> stall_cnt=15, no wrap.
//  6. PIPE_SKID_EN: out_ready=0, push 2 entries (A,B) -> third rejected (in_ready=0); release -> A then B in order.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared payload layout, default widths and skid-buffer state encoding
package ex_mem_pkg;
  localparam int DBITS_DEF = 32;
  localparam int RIW_DEF = 4;
  localparam int STALL_CNT_BITS_DEF = 16;
  typedef struct packed {
    logic [DBITS_DEF-1:0] alu_out;
    logic [DBITS_DEF-1:0] pc_inc;
    logic [DBITS_DEF-1:0] dmem_data;
    logic                 dmem_wrt_en;
    logic                 mem_to_reg;
    logic                 jal;
    logic                 reg_file_wrt_en;
    logic [RIW_DEF-1:0]   reg_wrt_index;
  } ex_mem_payload_t;
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} skid_state_e;
endpackage

// File: rtl/ex_mem_skid_buf.sv
// ex_mem_skid_buf: skid entry and occupancy FSM giving a registered in_ready (used when PIPE_SKID_EN is defined)
module ex_mem_skid_buf
  import ex_mem_pkg::*;
#(
  parameter type T = ex_mem_payload_t
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flush,
  input  logic in_valid,
  input  logic out_ready,
  input  T     din,
  output logic in_ready,
  output logic main_load,
  output logic take_skid,
  output logic main_full_nxt,
  output T     skid
);
  skid_state_e state, nxt;
  logic xin, xout, skid_load;
  assign xin = in_valid && in_ready;
  assign xout = state != EMPTY && out_ready;
  // State register; in_ready is registered from the next state so no comb path reaches upstream
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= EMPTY;
      in_ready <= 1'b0;
    end else begin
      state <= nxt;
      in_ready <= nxt != FULL;
    end
  end
  // Next-state: flush empties everything, otherwise track occupancy of main+skid
  always_comb begin
    nxt = flush ? EMPTY :
          state == EMPTY ? (xin ? BUSY : EMPTY) :
          state == BUSY ? (xin && !xout ? FULL : (!xin && xout ? EMPTY : BUSY)) :
          (xout ? BUSY : FULL);
  end
  // Outputs: main register loads from input, or from skid when draining a full buffer
  always_comb begin
    main_load = !flush && (state == EMPTY ? xin : state == BUSY ? xin && xout : xout);
    take_skid = state == FULL;
    skid_load = !flush && state == BUSY && xin && !xout;
    main_full_nxt = nxt != EMPTY;
  end
  // Skid entry captures an input arriving while main is stalled
  always_ff @(posedge clk) begin
    if (!reset_n) skid <= '0;
    else if (skid_load) skid <= din;
  end
endmodule

// File: rtl/ex_mem_pipe_stage.sv
// ex_mem_pipe_stage: elastic EX->MEM register with flush, gated enables and stall counter; PIPE_SKID_EN adds a 2-entry skid buffer
module ex_mem_pipe_stage
  import ex_mem_pkg::*;
#(
  parameter int DBITS = DBITS_DEF,
  parameter int REG_INDEX_BIT_WIDTH = RIW_DEF,
  parameter int STALL_CNT_BITS = STALL_CNT_BITS_DEF
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DBITS-1:0]               alu_out,
  input  logic [DBITS-1:0]               pc_inc,
  input  logic [DBITS-1:0]               dmem_data_in,
  input  logic                           dmem_wrt_en,
  input  logic                           mem_to_reg,
  input  logic                           jal,
  input  logic                           reg_file_wrt_en,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] reg_wrt_index,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DBITS-1:0]               dmem_addr_out,
  output logic [DBITS-1:0]               reg_file_alu_out_out,
  output logic [DBITS-1:0]               dmem_data_in_out,
  output logic [DBITS-1:0]               pc_inc_out,
  output logic                           dmem_wrt_en_out,
  output logic                           reg_file_wrt_en_out,
  output logic                           mem_to_reg_out,
  output logic                           jal_out,
  output logic [REG_INDEX_BIT_WIDTH-1:0] reg_wrt_index_out,
  output logic [STALL_CNT_BITS-1:0]      stall_cnt
);
  typedef struct packed {
    logic [DBITS-1:0]               alu_out;
    logic [DBITS-1:0]               pc_inc;
    logic [DBITS-1:0]               dmem_data;
    logic                           dmem_wrt_en;
    logic                           mem_to_reg;
    logic                           jal;
    logic                           reg_file_wrt_en;
    logic [REG_INDEX_BIT_WIDTH-1:0] reg_wrt_index;
  } payload_t;
  localparam logic [STALL_CNT_BITS-1:0] STALL_MAX = '1;
  payload_t din, main, load_data;
  logic load, valid_nxt;
  assign din = {alu_out, pc_inc, dmem_data_in, dmem_wrt_en, mem_to_reg, jal, reg_file_wrt_en, reg_wrt_index};
`ifdef PIPE_SKID_EN
  payload_t skid;
  logic take_skid;
  ex_mem_skid_buf #(.T(payload_t)) u_skid (
    .clk(clk),
    .reset_n(reset_n),
    .flush(flush),
    .in_valid(in_valid),
    .out_ready(out_ready),
    .din(din),
    .in_ready(in_ready),
    .main_load(load),
    .take_skid(take_skid),
    .main_full_nxt(valid_nxt),
    .skid(skid)
  );
  assign load_data = take_skid ? skid : din;
`else
  assign in_ready = !out_valid || out_ready;
  assign load = !flush && in_valid && in_ready;
  assign valid_nxt = !flush && (load || (out_valid && !out_ready));
  assign load_data = din;
`endif
  // Main register: valid tracks occupancy, payload only moves on a load
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      main <= '0;
    end else begin
      out_valid <= valid_nxt;
      if (load) main <= load_data;
    end
  end
  // Saturating count of cycles the downstream refused a valid entry
  always_ff @(posedge clk) begin
    if (!reset_n) stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + 1'b1;
  end
  assign dmem_addr_out = main.alu_out;
  assign reg_file_alu_out_out = main.alu_out;
  assign pc_inc_out = main.pc_inc;
  assign dmem_data_in_out = main.dmem_data;
  assign dmem_wrt_en_out = main.dmem_wrt_en && out_valid;
  assign reg_file_wrt_en_out = main.reg_file_wrt_en && out_valid;
  assign mem_to_reg_out = main.mem_to_reg;
  assign jal_out = main.jal;
  assign reg_wrt_index_out = main.reg_wrt_index;
endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// tb_ex_mem_pipe_stage: directed stimulus with a queue-based occupancy model checked every cycle (PIPE_SKID_EN selects skid expectations)
module tb_ex_mem_pipe_stage;
  localparam int SCB = 4;
  localparam int SMAX = 15;
  logic clk = 1'b0;
  logic reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] alu_out, pc_inc, dmem_data_in;
  logic dmem_wrt_en, mem_to_reg, jal, reg_file_wrt_en;
  logic [3:0] reg_wrt_index;
  logic [31:0] dmem_addr_out, reg_file_alu_out_out, dmem_data_in_out, pc_inc_out;
  logic dmem_wrt_en_out, reg_file_wrt_en_out, mem_to_reg_out, jal_out;
  logic [3:0] reg_wrt_index_out;
  logic [SCB-1:0] stall_cnt;
  int n_chk = 0, n_fail = 0;
  logic [103:0] q[$];
  int cnt_m = 0;
  logic rdy_flop = 1'b0;

  ex_mem_pipe_stage #(.DBITS(32), .REG_INDEX_BIT_WIDTH(4), .STALL_CNT_BITS(SCB)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .pc_inc(pc_inc), .dmem_data_in(dmem_data_in), .dmem_wrt_en(dmem_wrt_en),
    .mem_to_reg(mem_to_reg), .jal(jal), .reg_file_wrt_en(reg_file_wrt_en), .reg_wrt_index(reg_wrt_index),
    .out_valid(out_valid), .out_ready(out_ready), .dmem_addr_out(dmem_addr_out),
    .reg_file_alu_out_out(reg_file_alu_out_out), .dmem_data_in_out(dmem_data_in_out), .pc_inc_out(pc_inc_out),
    .dmem_wrt_en_out(dmem_wrt_en_out), .reg_file_wrt_en_out(reg_file_wrt_en_out), .mem_to_reg_out(mem_to_reg_out),
    .jal_out(jal_out), .reg_wrt_index_out(reg_wrt_index_out), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic rdy_m();
`ifdef PIPE_SKID_EN
    return rdy_flop;
`else
    return q.size() == 0 || out_ready;
`endif
  endfunction

  // Model: the stage is a FIFO of capacity 1 (2 with skid); flush empties it, reset clears everything
  always @(posedge clk) begin
    logic r;
    r = rdy_m();
    if (!reset_n) begin
      q.delete();
      cnt_m = 0;
      rdy_flop = 1'b0;
    end else begin
      if (q.size() > 0 && !out_ready && cnt_m < SMAX) cnt_m++;
      if (flush) begin
        q.delete();
        rdy_flop = 1'b1;
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && r)
          q.push_back({alu_out, pc_inc, dmem_data_in, dmem_wrt_en, mem_to_reg, jal, reg_file_wrt_en, reg_wrt_index});
        rdy_flop = q.size() < 2;
      end
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    logic [103:0] e;
    chk("out_valid", {135'd0, out_valid}, {135'd0, q.size() > 0});
    chk("in_ready", {135'd0, in_ready}, {135'd0, rdy_m()});
    chk("stall_cnt", {132'd0, stall_cnt}, 136'(cnt_m));
    if (q.size() > 0) begin
      e = q[0];
      chk("payload",
          {1'b0, dmem_addr_out, reg_file_alu_out_out, pc_inc_out, dmem_data_in_out, mem_to_reg_out, jal_out,
           reg_wrt_index_out, dmem_wrt_en_out, reg_file_wrt_en_out},
          {1'b0, e[103:72], e[103:72], e[71:40], e[39:8], e[6], e[5], e[3:0], e[7], e[4]});
    end else begin
      chk("wen_gate", {134'd0, dmem_wrt_en_out, reg_file_wrt_en_out}, 136'd0);
    end
  end

  task automatic put(input logic iv, input logic [31:0] a, input logic w);
    in_valid = iv;
    alu_out = a;
    pc_inc = a + 32'h1000;
    dmem_data_in = ~a;
    dmem_wrt_en = w;
    mem_to_reg = a[0];
    jal = a[1];
    reg_file_wrt_en = !w;
    reg_wrt_index = a[3:0];
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    put(1'b1, 32'h1234_5678, 1'b1);
    repeat (3) step();
    chk("rst_valid", {135'd0, out_valid}, 136'd0);
    chk("rst_payload",
        {1'b0, dmem_addr_out, reg_file_alu_out_out, pc_inc_out, dmem_data_in_out, mem_to_reg_out, jal_out,
         reg_wrt_index_out, dmem_wrt_en_out, reg_file_wrt_en_out}, 136'd0);
    chk("rst_stall", {132'd0, stall_cnt}, 136'd0);
`ifdef PIPE_SKID_EN
    chk("rst_in_ready", {135'd0, in_ready}, 136'd0);
`else
    chk("rst_in_ready", {135'd0, in_ready}, 136'd1);
`endif
    reset_n = 1'b1;
    put(1'b0, 32'h0, 1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      put(1'b1, 32'h10 + 32'(i), (i % 2) == 1);
      step();
      chk("stream_valid", {135'd0, out_valid}, 136'd1);
      chk("stream_addr", {104'd0, dmem_addr_out}, 136'(32'h10 + 32'(i)));
    end
    put(1'b0, 32'h0, 1'b0);
    step();
    chk("stream_drain", {135'd0, out_valid}, 136'd0);
    out_ready = 1'b0;
    put(1'b1, 32'hDEAD, 1'b1);
    step();
    put(1'b0, 32'h0, 1'b0);
    repeat (5) step();
    chk("stall_hold", {104'd0, reg_file_alu_out_out}, 136'h0DEAD);
    chk("stall_cnt5", {132'd0, stall_cnt}, 136'd5);
    out_ready = 1'b1;
    step();
    chk("stall_release", {135'd0, out_valid}, 136'd0);
    out_ready = 1'b0;
    put(1'b1, 32'h44, 1'b1);
    step();
    chk("flush_pre_wen", {135'd0, dmem_wrt_en_out}, 136'd1);
    flush = 1'b1;
    put(1'b1, 32'h55, 1'b1);
    step();
    flush = 1'b0;
    put(1'b0, 32'h0, 1'b0);
    chk("flush_valid", {135'd0, out_valid}, 136'd0);
    chk("flush_wen", {134'd0, dmem_wrt_en_out, reg_file_wrt_en_out}, 136'd0);
    chk("flush_stall", {132'd0, stall_cnt}, 136'd6);
    put(1'b1, 32'h77, 1'b0);
    step();
    put(1'b0, 32'h0, 1'b0);
    repeat (20) step();
    chk("sat_cnt", {132'd0, stall_cnt}, 136'd15);
    reset_n = 1'b0;
    step();
    chk("midstall_rst_cnt", {132'd0, stall_cnt}, 136'd0);
    chk("midstall_rst_valid", {135'd0, out_valid}, 136'd0);
    reset_n = 1'b1;
    step();
`ifdef PIPE_SKID_EN
    put(1'b1, 32'hA, 1'b1);
    step();
    put(1'b1, 32'hB, 1'b0);
    step();
    chk("skid_full_rdy", {135'd0, in_ready}, 136'd0);
    chk("skid_first", {104'd0, dmem_addr_out}, 136'hA);
    put(1'b1, 32'hC, 1'b1);
    step();
    put(1'b0, 32'h0, 1'b0);
    out_ready = 1'b1;
    step();
    chk("skid_second", {104'd0, dmem_addr_out}, 136'hB);
    chk("skid_second_valid", {135'd0, out_valid}, 136'd1);
    step();
    chk("skid_empty", {135'd0, out_valid}, 136'd0);
`else
    put(1'b1, 32'hA, 1'b1);
    step();
    chk("full_rdy", {135'd0, in_ready}, 136'd0);
    put(1'b1, 32'hB, 1'b0);
    out_ready = 1'b1;
    step();
    chk("replace_addr", {104'd0, dmem_addr_out}, 136'hB);
    chk("replace_valid", {135'd0, out_valid}, 136'd1);
    put(1'b0, 32'h0, 1'b0);
    step();
    chk("replace_drain", {135'd0, out_valid}, 136'd0);
`endif
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
